// File: rtl/dmem_access_arbiter.sv
// dmem_access_arbiter
// Shares one single-port, byte-addressed data memory between the pipeline
// MEM stage (cpu_*) and a debug/loader port (dbg_*). Each access runs through
// IDLE -> ACCESS -> RESP (or IDLE -> RESP for a rejected address), so the
// memory strobes are only high while the registered address and data are stable.
//
// Handshake: a requester raises req with we/addr/wdata and holds them until it
// sees a one-cycle ack; err/rdata are valid with that ack and hold afterwards.
// In the cycle after ack the requester drops req or presents a new transaction;
// any req seen in IDLE starts a new transaction. Request inputs are latched at
// grant, so later changes to them do not affect the access in flight.
module dmem_access_arbiter #(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int MEM_BYTES = 512
) (
  input  logic              clk,
  input  logic              reset,
  // pipeline MEM stage port
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_err,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  // debug / loader port
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic              dbg_err,
  output logic [DATA_W-1:0] dbg_rdata,
  // data memory side
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata,
  // status
  output logic              busy,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Port identifiers used for the owner and last-grant registers.
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(MEM_BYTES);
  localparam logic [ADDR_W:0] WORD_LAST  = (ADDR_W+1)'(3);

  state_t state;
  logic   own;       // port that owns the access in flight
  logic   lg;        // port granted most recently (loses the next tie)
  logic   lat_we;    // latched direction of the access in flight

  // Winner selection and the winner's request fields.
  logic              grant_dbg;
  logic              any_req;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [ADDR_W:0]   sel_addr_end;
  logic              sel_aligned;
  logic              sel_in_range;
  logic              sel_legal;
  logic [DATA_W-1:0] load_word;
  logic [DATA_W-1:0] store_word;

  // Upper data bits carry nothing in a 32-bit word access.
  logic unused_upper_bits;
  assign unused_upper_bits = ^{cpu_wdata[DATA_W-1:32], dbg_wdata[DATA_W-1:32],
                               mem_rdata[DATA_W-1:32]};

  // Round-robin pick: a lone requester wins; on a tie the port that was not
  // granted last wins.
  always_comb begin
    any_req   = cpu_req | dbg_req;
    grant_dbg = dbg_req & (~cpu_req | (lg == PORT_CPU));
    if (grant_dbg) begin
      sel_we    = dbg_we;
      sel_addr  = dbg_addr;
      sel_wdata = dbg_wdata;
    end else begin
      sel_we    = cpu_we;
      sel_addr  = cpu_addr;
      sel_wdata = cpu_wdata;
    end
  end

  // Legal iff word aligned and the last byte of the word lies inside memory.
  // The end address is computed one bit wider so a wrap near the top of the
  // address space cannot look in-range.
  always_comb begin
    sel_addr_end = {1'b0, sel_addr} + WORD_LAST;
    sel_aligned  = (sel_addr[1:0] == 2'b00);
    sel_in_range = (sel_addr_end < ADDR_LIMIT);
    sel_legal    = sel_aligned & sel_in_range;
  end

  // Word-sized views of the memory data paths, zero-extended to DATA_W.
  always_comb begin
    load_word  = {{(DATA_W-32){1'b0}}, mem_rdata[31:0]};
    store_word = {{(DATA_W-32){1'b0}}, sel_wdata[31:0]};
  end

  // Sequencer: grant, drive the memory for exactly one cycle, then respond.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      own       <= PORT_CPU;
      lg        <= PORT_DBG;
      lat_we    <= 1'b0;
      cpu_ack   <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= '0;
      dbg_ack   <= 1'b0;
      dbg_err   <= 1'b0;
      dbg_rdata <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
    end else begin
      // Acks are single-cycle pulses and strobes live only in ACCESS.
      cpu_ack   <= 1'b0;
      dbg_ack   <= 1'b0;
      mem_write <= 1'b0;
      mem_read  <= 1'b0;

      case (state)
        IDLE: begin
          if (any_req) begin
            own    <= grant_dbg;
            lg     <= grant_dbg;
            lat_we <= sel_we;
            if (sel_legal) begin
              state     <= ACCESS;
              mem_addr  <= sel_addr;
              mem_wdata <= store_word;
              mem_write <= sel_we;
              mem_read  <= ~sel_we;
            end else begin
              // Rejected: respond next cycle without touching memory.
              state <= RESP;
              if (grant_dbg) begin
                dbg_ack   <= 1'b1;
                dbg_err   <= 1'b1;
                dbg_rdata <= '0;
              end else begin
                cpu_ack   <= 1'b1;
                cpu_err   <= 1'b1;
                cpu_rdata <= '0;
              end
            end
          end
        end

        ACCESS: begin
          // Memory read data is sampled at the end of the strobe cycle.
          state <= RESP;
          if (own == PORT_DBG) begin
            dbg_ack   <= 1'b1;
            dbg_err   <= 1'b0;
            dbg_rdata <= lat_we ? '0 : load_word;
          end else begin
            cpu_ack   <= 1'b1;
            cpu_err   <= 1'b0;
            cpu_rdata <= lat_we ? '0 : load_word;
          end
        end

        RESP: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Stall the pipeline until its own ack arrives.
  assign cpu_stall = cpu_req & ~cpu_ack;
  assign busy      = (state != IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Bench for dmem_access_arbiter: a byte-array data memory model, driver tasks
// per transaction shape, a response scoreboard per port and a final report.
module tb_dmem_access_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          mem_init;
  logic          cpu_req, cpu_we, cpu_ack, cpu_err, cpu_stall;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dbg_req, dbg_we, dbg_ack, dbg_err;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_write, mem_read, busy;
  logic [1:0]    fsm_state;

  int n_checks = 0;
  int n_fail   = 0;
  int rd_cnt   = 0;
  int wr_cnt   = 0;

  logic [64:0] cpu_q[$];
  logic [64:0] dbg_q[$];

  logic [7:0] env_mem[512];
  logic [7:0] ref_mem[512];

  // clock / reset
  always #5 clk = ~clk;

  dmem_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_BYTES(512)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_err(dbg_err), .dbg_rdata(dbg_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_read(mem_read), .mem_rdata(mem_rdata),
    .busy(busy), .fsm_state(fsm_state)
  );

  // data memory: synchronous word write, combinational read, junk upper half
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 512; i++) env_mem[i] <= 8'h00;
      env_mem[256] <= 8'h07;
    end else if (mem_write && mem_addr <= 64'd508) begin
      for (int i = 0; i < 4; i++) env_mem[int'(mem_addr[8:0]) + i] <= mem_wdata[8*i +: 8];
    end
  end

  always_comb begin : rd_port
    int b;
    b = int'(mem_addr[8:0]);
    mem_rdata = '1;
    if (mem_addr <= 64'd508)
      mem_rdata = {32'hA5A5_5A5A, env_mem[b+3], env_mem[b+2], env_mem[b+1], env_mem[b]};
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // reference model: {err, rdata}; stores update the reference memory
  function automatic logic [64:0] model(input bit we, input logic [63:0] addr,
                                        input logic [63:0] wdata);
    int b;
    if (!(addr[1:0] == 2'b00 && addr <= 64'd508)) return {1'b1, 64'd0};
    b = int'(addr[8:0]);
    if (we) begin
      for (int i = 0; i < 4; i++) ref_mem[b+i] = wdata[8*i +: 8];
      return 65'd0;
    end
    return {1'b0, 32'd0, ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  // scoreboard: pop and compare on every ack; strobe counting
  always @(negedge clk) begin
    logic [64:0] e;
    if (mem_read)  rd_cnt++;
    if (mem_write) wr_cnt++;
    if (cpu_ack) begin
      check("cpu_ack_expected", 128'(cpu_q.size() > 0), 128'd1);
      if (cpu_q.size() > 0) begin
        e = cpu_q.pop_front();
        check("cpu_resp", {cpu_err, cpu_rdata}, e);
      end
    end
    if (dbg_ack) begin
      check("dbg_ack_expected", 128'(dbg_q.size() > 0), 128'd1);
      if (dbg_q.size() > 0) begin
        e = dbg_q.pop_front();
        check("dbg_resp", {dbg_err, dbg_rdata}, e);
      end
    end
  end

  // driver: one transaction on one port, latency and strobe checks
  task automatic run_txn(input bit port, input bit we, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [64:0] exp, input string name);
    int n; bit got; bit rd1, wr1; logic [63:0] addr1; int exp_lat; bit legal;
    legal   = ~exp[64];
    exp_lat = legal ? 2 : 1;
    rd1 = 1'b0; wr1 = 1'b0; addr1 = '0;
    if (port) dbg_q.push_back(exp); else cpu_q.push_back(exp);
    rd_cnt = 0; wr_cnt = 0;
    if (port) begin dbg_req = 1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; end
    else      begin cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; end
    n = 0; got = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) begin rd1 = mem_read; wr1 = mem_write; addr1 = mem_addr; end
      got = port ? dbg_ack : cpu_ack;
    end
    if (port) dbg_req = 0; else cpu_req = 0;
    check({name, "_latency"}, 128'(n), 128'(exp_lat));
    if (legal) begin
      check({name, "_strobe"}, {rd1, wr1}, {~we, we});
      check({name, "_addr"}, addr1, addr);
    end
    check({name, "_strobe_count"}, {64'(rd_cnt), 64'(wr_cnt)},
          {64'(legal && !we), 64'(legal && we)});
    @(negedge clk);
  endtask

  // driver: simultaneous loads on both ports
  task automatic tie(input string name, input bit dbg_first);
    int n, cpu_n, dbg_n;
    cpu_q.push_back(model(0, 64'd260, 64'd0));
    dbg_q.push_back(model(0, 64'd256, 64'd0));
    cpu_req = 1; cpu_we = 0; cpu_addr = 64'd260;
    dbg_req = 1; dbg_we = 0; dbg_addr = 64'd256;
    n = 0; cpu_n = 0; dbg_n = 0;
    while ((cpu_n == 0 || dbg_n == 0) && n < 20) begin
      @(negedge clk);
      n++;
      if (cpu_ack) begin cpu_n = n; cpu_req = 0; end
      if (dbg_ack) begin dbg_n = n; dbg_req = 0; end
    end
    cpu_req = 0; dbg_req = 0;
    check({name, "_cpu_ack_cycle"}, 128'(cpu_n), 128'(dbg_first ? 5 : 2));
    check({name, "_dbg_ack_cycle"}, 128'(dbg_n), 128'(dbg_first ? 2 : 5));
    @(negedge clk);
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [63:0] addr;
    logic [63:0] wdata;
    bit          exp_err;
    logic [63:0] exp_rdata;
  } vec_t;

  vec_t vecs[15];

  initial begin
    logic [64:0] e;
    logic [63:0] ra;
    bit rp, rw;

    vecs[0]  = '{0, 0, 64'd256, 64'd0, 0, 64'h7};
    vecs[1]  = '{0, 1, 64'd260, 64'h1111_2222_DEAD_BEEF, 0, 64'h0};
    vecs[2]  = '{0, 0, 64'd260, 64'd0, 0, 64'h0000_0000_DEAD_BEEF};
    vecs[3]  = '{1, 1, 64'd508, 64'hFFFF_FFFF_1234_5678, 0, 64'h0};
    vecs[4]  = '{1, 0, 64'd508, 64'd0, 0, 64'h0000_0000_1234_5678};
    vecs[5]  = '{0, 0, 64'd258, 64'd0, 1, 64'h0};
    vecs[6]  = '{0, 0, 64'd510, 64'd0, 1, 64'h0};
    vecs[7]  = '{1, 1, 64'd512, 64'h55, 1, 64'h0};
    vecs[8]  = '{0, 1, 64'd509, 64'h66, 1, 64'h0};
    vecs[9]  = '{0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 1, 64'h0};
    vecs[10] = '{1, 0, 64'd260, 64'd0, 0, 64'h0000_0000_DEAD_BEEF};
    vecs[11] = '{0, 0, 64'd0, 64'd0, 0, 64'h0};
    vecs[12] = '{0, 1, 64'd0, 64'h0000_00A5, 0, 64'h0};
    vecs[13] = '{1, 0, 64'd0, 64'd0, 0, 64'hA5};
    vecs[14] = '{1, 0, 64'd504, 64'd0, 0, 64'h0};

    for (int i = 0; i < 512; i++) ref_mem[i] = 8'h00;
    ref_mem[256] = 8'h07;

    reset = 1; mem_init = 1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    repeat (3) @(negedge clk);
    check("reset_cpu_outputs", {cpu_ack, cpu_err, cpu_rdata, cpu_stall}, 128'd0);
    check("reset_dbg_outputs", {dbg_ack, dbg_err, dbg_rdata}, 128'd0);
    check("reset_mem_addr", mem_addr, 128'd0);
    check("reset_mem_wdata", mem_wdata, 128'd0);
    check("reset_strobes_state", {mem_write, mem_read, busy, fsm_state}, 128'd0);
    reset = 0; mem_init = 0;
    @(negedge clk);

    // tie right after reset: CPU first; after a CPU solo grant: DBG first
    tie("tie_after_reset", 1'b0);
    run_txn(0, 0, 64'd256, 64'd0, model(0, 64'd256, 64'd0), "cpu_solo");
    tie("tie_after_cpu", 1'b1);

    // table-driven vectors
    for (int i = 0; i < 15; i++) begin
      void'(model(vecs[i].we, vecs[i].addr, vecs[i].wdata));
      run_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
              {vecs[i].exp_err, vecs[i].exp_rdata}, $sformatf("vec%0d", i));
    end

    // stall tracking, input changes after grant ignored, rdata holds after ack
    e = model(0, 64'd256, 64'd0);
    cpu_q.push_back(e);
    wr_cnt = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 64'd256;
    #1 check("stall_cycle_n", cpu_stall, 128'd1);
    @(negedge clk);
    check("stall_cycle_n1", cpu_stall, 128'd1);
    cpu_addr = 64'd3; cpu_we = 1;
    @(negedge clk);
    check("stall_ack_cycle", {cpu_ack, cpu_stall}, {1'b1, 1'b0});
    cpu_req = 0; cpu_we = 0;
    #1 check("stall_after_drop", cpu_stall, 128'd0);
    repeat (2) @(negedge clk);
    check("rdata_hold", {cpu_ack, cpu_err, cpu_rdata}, {1'b0, e});
    check("no_write_from_changed_inputs", 128'(wr_cnt), 128'd0);

    // random traffic against the reference model
    for (int i = 0; i < 30; i++) begin
      rp = 1'($urandom_range(0, 1));
      rw = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) ra = {$urandom, $urandom};
      else ra = 64'($urandom_range(0, 127)) * 64'd4;
      cpu_wdata = {$urandom, $urandom};
      e = model(rw, ra, cpu_wdata);
      run_txn(rp, rw, ra, cpu_wdata, e, $sformatf("rnd%0d", i));
    end

    // reset during the ACCESS cycle of a DBG store
    dbg_req = 1; dbg_we = 1; dbg_addr = 64'd64; dbg_wdata = 64'h0BAD_F00D;
    @(negedge clk);
    check("rst_mid_access_write", {mem_write, fsm_state}, {1'b1, 2'd1});
    reset = 1;
    @(negedge clk);
    dbg_req = 0; dbg_we = 0;
    check("rst_mid_no_ack", dbg_ack, 128'd0);
    check("rst_mid_idle", {fsm_state, busy, mem_write, mem_read}, 128'd0);
    reset = 0;
    repeat (3) @(negedge clk);
    run_txn(0, 0, 64'd256, 64'd0, model(0, 64'd256, 64'd0), "after_reset_load");

    check("cpu_q_drained", 128'(cpu_q.size()), 128'd0);
    check("dbg_q_drained", 128'(dbg_q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
